mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Load/store stage directly downstream of the single-cycle datapath's ALU and WriteData outputs. It turns the core's combinational memory request into a registered valid/ready bus transaction and returns ReadData to the result mux. It supports word and byte (LDRB/STRB) accesses. It stalls the core with Stall until the bus completes.

Parameters:
AW, 32, bus/core address width
DW, 32, data width; fixed at 32, four byte lanes
TIMEOUT_CYCLES, 255, BUSY cycles without BusReady before abort; used only with the optional feature

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high
MemReq  in  1  core requests a memory access this cycle (LDR/STR decoded)
MemWrite  in  1  1 = store, 0 = load
MemByte  in  1  1 = byte access, 0 = word access
Addr  in  AW  effective address (ALUResult)
WriteData  in  DW  store data from register file
ReadData  out  DW  load result to the result mux
Stall  out  1  freeze PC and register-file write
BusValid  out  1  request valid
BusReady  in  1  slave accepts and completes the request
BusWe  out  1  write enable
BusAddr  out  AW  word-aligned address
BusWStrb  out  4  byte-lane write strobes
BusWData  out  DW  lane-steered write data
BusRData  in  DW  read data; valid when BusValid & BusReady & ~BusWe
Fault  out  1  timeout flag; optional feature only

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset (asynchronous, active-high): state=IDLE, BusValid=0, BusWe=0, BusAddr=0, BusWStrb=0, BusWData=0, ReadData=0, Fault=0. Stall follows the combinational rule below.
- Reset asserted mid-transaction: BusValid drops in the same instant and the transaction is abandoned; the slave must tolerate this.
- IDLE:
  - Stall = MemReq (combinational).
  - If MemReq, on the next edge: latch BusAddr={Addr[AW-1:2],2'b00}, BusWe=MemWrite, strobes, and data; go to BUSY.
- BUSY:
  - BusValid=1, Stall=1. BusAddr, BusWe, BusWStrb and BusWData stay stable until the BusReady handshake.
  - BusValid&BusReady: capture the load result into ReadData (stores leave ReadData unchanged); go to RESP.
- RESP:
  - Stall=0 for exactly one cycle; the core commits the result and advances the PC; BusValid=0.
  - MemReq is ignored in this cycle, since it is the same instruction; unconditional transition to IDLE.
- Minimum access latency is 3 cycles (IDLE, BUSY with BusReady=1, RESP). Each extra wait cycle adds one.
- Word access: BusWStrb=4'b1111, BusWData=WriteData. Addr[1:0] is ignored; no alignment fault.
- Byte store: BusWStrb=4'b0001<<Addr[1:0]; BusWData={4{WriteData[7:0]}}.
- Byte load: ReadData={24'b0, lane Addr[1:0] of BusRData}, zero-extended. Lane 0 is bits [7:0] (little-endian).
- MemReq=0 in IDLE: no bus activity, Stall=0, ReadData holds its last value.
- BusReady while BusValid=0 is ignored.

Optional Feature:
MAU_TIMEOUT_EN
- Defined:
  - An 8+-bit counter clears on entry to BUSY and increments each BUSY cycle without BusReady.
  - When it reaches TIMEOUT_CYCLES: drop BusValid, set ReadData=32'hDEADBEEF, set Fault=1, go to RESP.
  - Fault is sticky until reset.
- Undefined: no counter; BUSY waits indefinitely; Fault tied to 0.

Decomposition:
- Package mau_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - constants STRB_WORD=4'b1111, STRB_BYTE0=4'b0001, TIMEOUT_DATA=32'hDEADBEEF.
- One sub-module, mem_lane_align: purely combinational. It generates the store strobe/data replication and the load byte extraction with zero-extension. It is reused by any future halfword support.

Test Plan:
- Word load, BusReady on the first BUSY cycle. Addr=0x100, BusRData=0x12345678 -> BusAddr=0x100, BusWStrb=0000, Stall high for 2 cycles, ReadData=0x12345678 in RESP.
- Byte store. Addr=0x203, WriteData=0xAABBCCDD -> BusAddr=0x200, BusWStrb=1000, BusWData=0xDDDDDDDD, BusWe=1.
- Byte load. Addr=0x301, BusRData=0x11223344 -> ReadData=0x00000033.
- BusReady held low for 5 cycles -> BusAddr/BusWData stable throughout, Stall high for 7 cycles total, single RESP cycle.
- Back-to-back: MemReq held high through RESP -> exactly one transaction per instruction; next BUSY starts 2 cycles after RESP.
- Reset asserted in BUSY -> BusValid=0 immediately, state IDLE.
- With MAU_TIMEOUT_EN and TIMEOUT_CYCLES=4, BusReady never asserted -> Fault=1, ReadData=0xDEADBEEF, state returns to IDLE.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared types and constants for the memory access unit.
//   mau_state_e  - FSM state encoding (IDLE, BUSY, RESP)
//   STRB_*       - byte-lane write strobe patterns
//   TIMEOUT_DATA - load result returned when a bus access is aborted
//   byte_strb()  - one-hot strobe for a single byte lane
package mau_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mau_state_e;

   localparam logic [3:0]  STRB_WORD    = 4'b1111;
   localparam logic [3:0]  STRB_BYTE0   = 4'b0001;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

   // One-hot strobe for byte lane 0..3 (lane 0 = bits [7:0]).
   function automatic logic [3:0] byte_strb(input logic [1:0] lane);
      return STRB_BYTE0 << lane;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: valid/ready memory bus between the access unit and a slave.
//   BusValid  - request valid (master)
//   BusReady  - slave accepts and completes the request (slave)
//   BusWe     - write enable (master)
//   BusAddr   - word-aligned address (master)
//   BusWStrb  - byte-lane write strobes (master)
//   BusWData  - lane-steered write data (master)
//   BusRData  - read data, valid on BusValid & BusReady & ~BusWe (slave)
interface mem_access_unit_if #(
   parameter int AW = 32,
   parameter int DW = 32
);

   logic          BusValid;
   logic          BusReady;
   logic          BusWe;
   logic [AW-1:0] BusAddr;
   logic [3:0]    BusWStrb;
   logic [DW-1:0] BusWData;
   logic [DW-1:0] BusRData;

   modport master (
      output BusValid, BusWe, BusAddr, BusWStrb, BusWData,
      input  BusReady, BusRData
   );

   modport slave (
      input  BusValid, BusWe, BusAddr, BusWStrb, BusWData,
      output BusReady, BusRData
   );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational byte-lane steering.
//   Store side: st_byte, st_lane, st_data -> st_strb (access strobes), st_wdata
//               (byte accesses replicate the low byte onto all four lanes).
//   Load side:  ld_byte, ld_lane, ld_rdata -> ld_data (byte accesses pick one
//               lane and zero-extend; word accesses pass through).
// Store and load lanes are separate inputs so the store side can be fed from
// the live request while the load side uses the lane latched with the request.
module mem_lane_align
   import mau_pkg::*;
(
   input  logic        st_byte,
   input  logic [1:0]  st_lane,
   input  logic [31:0] st_data,
   output logic [3:0]  st_strb,
   output logic [31:0] st_wdata,
   input  logic        ld_byte,
   input  logic [1:0]  ld_lane,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0] ld_sel;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      st_strb  = STRB_WORD;
      st_wdata = st_data;
      ld_sel   = ld_rdata[7:0];
      ld_data  = ld_rdata;

      if (st_byte) begin
         st_strb  = byte_strb(st_lane);
         st_wdata = {4{st_data[7:0]}};
      end

      case (ld_lane)
         2'd0:    ld_sel = ld_rdata[7:0];
         2'd1:    ld_sel = ld_rdata[15:8];
         2'd2:    ld_sel = ld_rdata[23:16];
         default: ld_sel = ld_rdata[31:24];
      endcase

      if (ld_byte)
         ld_data = {24'b0, ld_sel};
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage turning the core's combinational memory
// request into a registered valid/ready bus transaction.
//   clk, reset         - core clock, asynchronous active-high reset
//   MemReq/MemWrite/MemByte/Addr/WriteData - core-side request
//   ReadData           - load result to the result mux
//   Stall              - freezes PC and register-file write until completion
//   Fault              - sticky timeout flag (0 unless MAU_TIMEOUT_EN)
//   bus                - mem_access_unit_if master modport
// Optional build macro MAU_TIMEOUT_EN: abort a BUSY access after
// TIMEOUT_CYCLES cycles without BusReady, returning TIMEOUT_DATA and Fault=1.
// Access sequence: IDLE (request seen) -> BUSY (until BusReady) -> RESP (one
// cycle with Stall low so the core commits) -> IDLE.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MemReq,
   input  logic            MemWrite,
   input  logic            MemByte,
   input  logic [AW-1:0]   Addr,
   input  logic [DW-1:0]   WriteData,
   output logic [DW-1:0]   ReadData,
   output logic            Stall,
   output logic            Fault,
   mem_access_unit_if.master bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_BUSY = BUSY;
   localparam logic [1:0] S_RESP = RESP;

   logic [1:0]    state;
   logic          bus_we_q;
   logic [AW-1:0] bus_addr_q;
   logic [3:0]    bus_strb_q;
   logic [DW-1:0] bus_wdata_q;
   logic          ld_byte_q;
   logic [1:0]    ld_lane_q;

   logic [3:0]    st_strb;
   logic [31:0]   st_wdata;
   logic [31:0]   ld_data;

   mem_lane_align u_align (
      .st_byte  (MemByte),
      .st_lane  (Addr[1:0]),
      .st_data  (WriteData),
      .st_strb  (st_strb),
      .st_wdata (st_wdata),
      .ld_byte  (ld_byte_q),
      .ld_lane  (ld_lane_q),
      .ld_rdata (bus.BusRData),
      .ld_data  (ld_data)
   );

   // BusValid is decoded from state so an asynchronous reset drops it at once.
   assign bus.BusValid = (state == S_BUSY);
   assign bus.BusWe    = bus_we_q;
   assign bus.BusAddr  = bus_addr_q;
   assign bus.BusWStrb = bus_strb_q;
   assign bus.BusWData = bus_wdata_q;

   assign Stall = ((state == S_IDLE) && MemReq) || (state == S_BUSY);

`ifdef MAU_TIMEOUT_EN
   localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW   = (CLOG > 8) ? CLOG : 8;

   logic [CW-1:0] wait_cnt;
   logic          fault_q;

   assign Fault = fault_q;
`else
   assign Fault = 1'b0;
   // Keeps the parameter referenced when the timeout logic is compiled out.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_strb_q  <= 4'b0000;
         bus_wdata_q <= '0;
         ld_byte_q   <= 1'b0;
         ld_lane_q   <= 2'd0;
         ReadData    <= '0;
`ifdef MAU_TIMEOUT_EN
         wait_cnt    <= '0;
         fault_q     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (MemReq) begin
                  state       <= S_BUSY;
                  bus_we_q    <= MemWrite;
                  bus_addr_q  <= {Addr[AW-1:2], 2'b00};
                  // Loads drive no write strobes.
                  bus_strb_q  <= MemWrite ? st_strb : 4'b0000;
                  bus_wdata_q <= st_wdata;
                  ld_byte_q   <= MemByte;
                  ld_lane_q   <= Addr[1:0];
`ifdef MAU_TIMEOUT_EN
                  wait_cnt    <= '0;
`endif
               end
            end

            S_BUSY: begin
               if (bus.BusReady) begin
                  if (!bus_we_q)
                     ReadData <= ld_data;
                  state <= S_RESP;
               end
`ifdef MAU_TIMEOUT_EN
               // Abort on the TIMEOUT_CYCLES-th consecutive cycle without BusReady.
               else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  ReadData <= TIMEOUT_DATA;
                  fault_q  <= 1'b1;
                  state    <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end

            // MemReq here still belongs to the instruction just completed.
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Inputs change 1 time unit after each rising edge; outputs are compared in
// the same window, well away from the next edge.
// Build with MAU_TIMEOUT_EN defined to include the timeout sequence.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReq;
   logic        MemWrite;
   logic        MemByte;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Stall;
   logic        Fault;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_unit_if #(.AW(32), .DW(32)) bus ();

   mem_access_unit #(
      .AW             (32),
      .DW             (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemReq    (MemReq),
      .MemWrite  (MemWrite),
      .MemByte   (MemByte),
      .Addr      (Addr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Stall     (Stall),
      .Fault     (Fault),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
         $error("check %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int         stall_cnt;
   logic       stable_ok;
   logic [4:0] valid_v;
   logic [4:0] stall_v;
   int         n_wait;

   initial begin
      reset        = 1'b1;
      MemReq       = 1'b0;
      MemWrite     = 1'b0;
      MemByte      = 1'b0;
      Addr         = 32'h0;
      WriteData    = 32'h0;
      bus.BusReady = 1'b0;
      bus.BusRData = 32'h0;

      // Reset state
      tick();
      check("rst_valid", bus.BusValid, 1'b0);
      check("rst_we",    bus.BusWe,    1'b0);
      check("rst_addr",  bus.BusAddr,  32'h0);
      check("rst_strb",  bus.BusWStrb, 4'h0);
      check("rst_wdata", bus.BusWData, 32'h0);
      check("rst_rdata", ReadData,     32'h0);
      check("rst_fault", Fault,        1'b0);
      check("rst_stall", Stall,        1'b0);
      reset = 1'b0;
      tick();

      // Word load, BusReady on the first BUSY cycle
      MemReq = 1'b1; MemWrite = 1'b0; MemByte = 1'b0; Addr = 32'h100;
      #1;
      check("wl_idle_stall", Stall, 1'b1);
      check("wl_idle_valid", bus.BusValid, 1'b0);
      tick();
      bus.BusReady = 1'b1; bus.BusRData = 32'h12345678;
      #1;
      check("wl_busy_valid", bus.BusValid, 1'b1);
      check("wl_busy_addr",  bus.BusAddr,  32'h100);
      check("wl_busy_strb",  bus.BusWStrb, 4'b0000);
      check("wl_busy_we",    bus.BusWe,    1'b0);
      check("wl_busy_stall", Stall,        1'b1);
      tick();
      bus.BusReady = 1'b0; MemReq = 1'b0;
      #1;
      check("wl_resp_stall", Stall,        1'b0);
      check("wl_resp_valid", bus.BusValid, 1'b0);
      check("wl_resp_rdata", ReadData,     32'h12345678);
      tick();

      // BusReady with BusValid low must be ignored; ReadData holds
      bus.BusReady = 1'b1; bus.BusRData = 32'hFFFFFFFF;
      tick();
      tick();
      check("idle_ready_rdata", ReadData,     32'h12345678);
      check("idle_ready_valid", bus.BusValid, 1'b0);
      check("idle_ready_stall", Stall,        1'b0);
      bus.BusReady = 1'b0;

      // Byte store at 0x203
      MemReq = 1'b1; MemWrite = 1'b1; MemByte = 1'b1; Addr = 32'h203; WriteData = 32'hAABBCCDD;
      tick();
      bus.BusReady = 1'b1;
      #1;
      check("bs_addr",  bus.BusAddr,  32'h200);
      check("bs_strb",  bus.BusWStrb, 4'b1000);
      check("bs_wdata", bus.BusWData, 32'hDDDDDDDD);
      check("bs_we",    bus.BusWe,    1'b1);
      tick();
      bus.BusReady = 1'b0; MemReq = 1'b0;
      #1;
      check("bs_resp_stall", Stall,    1'b0);
      check("bs_rdata_kept", ReadData, 32'h12345678);
      tick();

      // Byte load at 0x301 -> lane 1, zero-extended
      MemReq = 1'b1; MemWrite = 1'b0; MemByte = 1'b1; Addr = 32'h301;
      tick();
      bus.BusReady = 1'b1; bus.BusRData = 32'h11223344;
      #1;
      check("bl_addr", bus.BusAddr, 32'h300);
      tick();
      bus.BusReady = 1'b0; MemReq = 1'b0;
      #1;
      check("bl_rdata", ReadData, 32'h00000033);
      tick();

      // Word store with 5 wait cycles; Addr[1:0] ignored
      MemReq = 1'b1; MemWrite = 1'b1; MemByte = 1'b0; Addr = 32'h406; WriteData = 32'hCAFEF00D;
      stall_cnt = 0;
      stable_ok = 1'b1;
      #1;
      stall_cnt += int'(Stall);
      tick();
      for (int i = 0; i < 5; i++) begin
         if (bus.BusAddr !== 32'h404 || bus.BusWData !== 32'hCAFEF00D ||
             bus.BusWStrb !== 4'b1111 || bus.BusValid !== 1'b1)
            stable_ok = 1'b0;
         stall_cnt += int'(Stall);
         tick();
      end
      bus.BusReady = 1'b1;
      #1;
      check("ws_last_addr", bus.BusAddr, 32'h404);
      stall_cnt += int'(Stall);
      tick();
      bus.BusReady = 1'b0; MemReq = 1'b0;
      #1;
      check("ws_resp_stall", Stall, 1'b0);
      stall_cnt += int'(Stall);
      check("ws_stable",    stable_ok, 1'b1);
      check("ws_stall_cnt", stall_cnt, 32'd7);
      tick();

      // Back-to-back: MemReq held high through RESP
      MemReq = 1'b1; MemWrite = 1'b0; MemByte = 1'b0; Addr = 32'h500;
      bus.BusReady = 1'b1; bus.BusRData = 32'hA5A5A5A5;
      for (int i = 0; i < 5; i++) begin
         #1;
         valid_v[i] = bus.BusValid;
         stall_v[i] = Stall;
         tick();
      end
      check("b2b_valid_pattern", valid_v, 5'b10010);
      check("b2b_stall_pattern", stall_v, 5'b11011);
      MemReq = 1'b0; bus.BusReady = 1'b0;
      #1;
      check("b2b_rdata", ReadData, 32'hA5A5A5A5);
      tick();

      // Reset asserted in BUSY
      MemReq = 1'b1; MemWrite = 1'b0; MemByte = 1'b0; Addr = 32'h604;
      tick();
      check("rb_busy_valid", bus.BusValid, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      check("rb_valid_drop", bus.BusValid, 1'b0);
      check("rb_addr",       bus.BusAddr,  32'h0);
      check("rb_rdata",      ReadData,     32'h0);
      check("rb_stall_idle", Stall,        1'b1);
      @(negedge clk);
      reset = 1'b0; MemReq = 1'b0;
      tick();
      check("rb_after_valid", bus.BusValid, 1'b0);
      check("rb_after_stall", Stall,        1'b0);

      // Recovery after reset: plain word load
      MemReq = 1'b1; Addr = 32'h700;
      tick();
      bus.BusReady = 1'b1; bus.BusRData = 32'h0BADF00D;
      tick();
      bus.BusReady = 1'b0; MemReq = 1'b0;
      #1;
      check("rec_rdata", ReadData, 32'h0BADF00D);
      tick();

`ifdef MAU_TIMEOUT_EN
      // Timeout with TIMEOUT_CYCLES=4, BusReady never asserted
      MemReq = 1'b1; MemWrite = 1'b0; MemByte = 1'b0; Addr = 32'h800;
      tick();
      MemReq = 1'b0;
      n_wait = 0;
      while (Stall && n_wait < 20) begin
         n_wait++;
         tick();
      end
      check("to_busy_cycles", n_wait,       32'd4);
      check("to_fault",       Fault,        1'b1);
      check("to_rdata",       ReadData,     32'hDEADBEEF);
      check("to_valid",       bus.BusValid, 1'b0);
      tick();
      check("to_idle_stall",  Stall,        1'b0);
      check("to_fault_stick", Fault,        1'b1);
`else
      check("no_timeout_fault", Fault, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
